regs_wb_scoreboard: RTL and testbench

- Sequences the integer register file's single write port.
- Tracks which architectural registers have writes in flight (scoreboard) and stalls decode issue on RAW/WAW hazards.
- Arbitrates two writeback requesters (ALU/CSR path, LSU path) onto the one write port.
- Sits between decode/issue, the execute/memory units, and the register file write port (rd/dest/write-enable).

---
 rtl/regs_wb_scoreboard.sv | 115 +++++++++++
 tb/tb_regs_wb_scoreboard.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regs_wb_scoreboard.sv
// Integer register-file write sequencer: hazard scoreboard, issue stall and two-way writeback arbiter.
// Optional REGS_WB_STAT_EN adds saturating stall / conflict counters.
module regs_wb_scoreboard #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic                     issue_we,
  input  logic [$clog2(NREG)-1:0]  issue_rd,
  input  logic [$clog2(NREG)-1:0]  issue_rs1,
  input  logic [$clog2(NREG)-1:0]  issue_rs2,
  output logic                     issue_ready,
  input  logic                     alu_wb_valid,
  input  logic [$clog2(NREG)-1:0]  alu_wb_rd,
  input  logic [XLEN-1:0]          alu_wb_data,
  output logic                     alu_wb_ready,
  input  logic                     lsu_wb_valid,
  input  logic [$clog2(NREG)-1:0]  lsu_wb_rd,
  input  logic [XLEN-1:0]          lsu_wb_data,
  output logic                     lsu_wb_ready,
  output logic                     rf_we,
  output logic [$clog2(NREG)-1:0]  rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic [NREG-1:0]          busy_vec,
  output logic                     wb_err
`ifdef REGS_WB_STAT_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              conflict_cnt
`endif
);
  localparam int RW = $clog2(NREG);

  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  logic [NREG-1:0] busy, busy_nxt;
  logic            alu_last;      // 1: ALU won the most recent conflict
  logic [1:0]      flush_hist;    // flush seen one / two cycles ago
  logic            hz1, hz2, hzw, fire;
  logic            conflict, gnt_any;
  wb_req_t         gnt_req;

  // Hazards look only at registered busy state; a same-cycle clear is not bypassed.
  assign hz1 = busy[issue_rs1] && (issue_rs1 != '0);
  assign hz2 = busy[issue_rs2] && (issue_rs2 != '0);
  assign hzw = issue_we && (issue_rd != '0) && busy[issue_rd];
  assign issue_ready = !flush && !hz1 && !hz2 && !hzw;
  assign fire = issue_valid && issue_ready;

  assign conflict     = alu_wb_valid && lsu_wb_valid;
  assign alu_wb_ready = !rst && alu_wb_valid && (!lsu_wb_valid || !alu_last);
  assign lsu_wb_ready = !rst && lsu_wb_valid && (!alu_wb_valid || alu_last);
  assign gnt_any      = alu_wb_ready || lsu_wb_ready;

  always_comb begin
    gnt_req = '0;
    if (alu_wb_ready)      gnt_req = '{rd: alu_wb_rd, data: alu_wb_data};
    else if (lsu_wb_ready) gnt_req = '{rd: lsu_wb_rd, data: lsu_wb_data};
  end

  always_comb begin
    busy_nxt = busy;
    if (gnt_any) busy_nxt[gnt_req.rd] = 1'b0;
    if (fire && issue_we) busy_nxt[issue_rd] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      alu_last   <= 1'b0;
      flush_hist <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      wb_err     <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      flush_hist <= {flush_hist[0], flush};
      if (conflict) alu_last <= alu_wb_ready;
      rf_we <= gnt_any && (gnt_req.rd != '0);
      if (gnt_any) begin
        rf_waddr <= gnt_req.rd;
        rf_wdata <= gnt_req.data;
      end
      // Results landing around a flush legitimately target cleared registers.
      if (gnt_any && (gnt_req.rd != '0) && !busy[gnt_req.rd] && !flush && (flush_hist == 2'b00))
        wb_err <= 1'b1;
    end
  end

  assign busy_vec = busy;

`ifdef REGS_WB_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (issue_valid && !issue_ready && !flush && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (conflict && (conflict_cnt != 32'hFFFF_FFFF))
        conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regs_wb_scoreboard.sv
// Bench for regs_wb_scoreboard: directed scenarios then randomized traffic against a set-based model.
module tb_regs_wb_scoreboard;
  logic        clk = 1'b0;
  logic        rst, flush, issue_valid, issue_we;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_ready;
  logic        alu_wb_valid, alu_wb_ready, lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  alu_wb_rd, lsu_wb_rd;
  logic [63:0] alu_wb_data, lsu_wb_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] busy_vec;
  logic        wb_err;
`ifdef REGS_WB_STAT_EN
  logic [31:0] stall_cnt, conflict_cnt;
`endif

  regs_wb_scoreboard #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_ready(issue_ready),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .lsu_wb_ready(lsu_wb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_vec(busy_vec), .wb_err(wb_err)
`ifdef REGS_WB_STAT_EN
    , .stall_cnt(stall_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: set of in-flight destinations, last conflict winner, write port image.
  bit          m_busy [32];
  bit          m_alu_won_last;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [63:0] m_wd;
  logic        m_err;
  int          cyc, m_last_flush;
  logic [31:0] m_stall, m_conf;
  logic        g_ga, g_gl;

  function automatic logic [31:0] busy_word();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w[i] = m_busy[i];
    return w;
  endfunction

  function automatic logic [4:0] pick_rd();
    logic [4:0] c[$];
    for (int i = 1; i < 32; i++) if (m_busy[i]) c.push_back(5'(i));
    if (($urandom % 10 == 0) || (c.size() == 0)) return 5'($urandom % 12);
    return c[$urandom % c.size()];
  endfunction

  // One clock: check combinational outputs against the model, advance, check registered outputs.
  task automatic cycle();
    bit          ir, ga, gl, stalled;
    logic [4:0]  r;
    logic [63:0] d;
    #1;
    ir = !flush
       && !(m_busy[issue_rs1] && issue_rs1 != 0)
       && !(m_busy[issue_rs2] && issue_rs2 != 0)
       && !(issue_we && issue_rd != 0 && m_busy[issue_rd]);
    if (rst) begin
      ga = 0; gl = 0;
    end else if (alu_wb_valid && lsu_wb_valid) begin
      ga = !m_alu_won_last; gl = m_alu_won_last;
    end else begin
      ga = alu_wb_valid; gl = lsu_wb_valid;
    end
    stalled = issue_valid && !ir && !flush;
    chk("issue_ready", issue_ready, ir);
    chk("alu_ready", alu_wb_ready, ga);
    chk("lsu_ready", lsu_wb_ready, gl);
    g_ga = ga; g_gl = gl;
    @(posedge clk);
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_alu_won_last = 0; m_we = 0; m_wa = 0; m_wd = 0; m_err = 0;
      m_last_flush = -100; m_stall = 0; m_conf = 0;
    end else begin
      m_we = 0;
      if (ga || gl) begin
        r = ga ? alu_wb_rd : lsu_wb_rd;
        d = ga ? alu_wb_data : lsu_wb_data;
        m_we = (r != 0); m_wa = r; m_wd = d;
        if (r != 0 && !m_busy[r] && !flush && (cyc - m_last_flush) > 2) m_err = 1;
        m_busy[r] = 0;
      end
      if (issue_valid && ir && issue_we && issue_rd != 0) m_busy[issue_rd] = 1;
      if (flush) begin
        foreach (m_busy[i]) m_busy[i] = 0;
        m_last_flush = cyc;
      end
      if (alu_wb_valid && lsu_wb_valid) m_alu_won_last = ga;
      if (stalled && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (alu_wb_valid && lsu_wb_valid && m_conf != 32'hFFFF_FFFF) m_conf++;
    end
    cyc++;
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_wa);
    chk("rf_wdata", rf_wdata, m_wd);
    chk("busy_vec", busy_vec, busy_word());
    chk("wb_err", wb_err, m_err);
`ifdef REGS_WB_STAT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("conflict_cnt", conflict_cnt, m_conf);
`endif
  endtask

  task automatic set_issue(input bit v, input bit we, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2);
    issue_valid = v; issue_we = we; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
  endtask

  initial begin
    cyc = 0; m_last_flush = -100;
    rst = 1; flush = 0;
    set_issue(0, 0, 0, 0, 0);
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
    @(negedge clk);
    cycle();
    chk("rst_busy", busy_vec, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_wdata", rf_wdata, 0);
    rst = 0;

    // RAW stall released by ALU writeback; dependent issues with rf_we
    set_issue(1, 1, 5, 0, 0); cycle();
    set_issue(1, 0, 0, 5, 0);
    alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 64'h1234; cycle();
    chk("raw_rf_we", rf_we, 1);
    chk("raw_waddr", rf_waddr, 5);
    chk("raw_wdata", rf_wdata, 64'h1234);
    chk("raw_ready_t1", issue_ready, 1);
    alu_wb_valid = 0; cycle();

    // Round-robin: ALU wins the first conflict, LSU the next
    set_issue(1, 1, 3, 0, 0); cycle();
    set_issue(1, 1, 7, 0, 0); cycle();
    set_issue(0, 0, 0, 0, 0);
    alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 64'hA3;
    lsu_wb_valid = 1; lsu_wb_rd = 7; lsu_wb_data = 64'hB7; cycle();
    chk("arb1_alu", rf_waddr, 3);
    alu_wb_valid = 0; cycle();
    chk("arb1_lsu", rf_waddr, 7);
    lsu_wb_valid = 0;
    set_issue(1, 1, 3, 0, 0); cycle();
    set_issue(1, 1, 7, 0, 0); cycle();
    set_issue(0, 0, 0, 0, 0);
    alu_wb_valid = 1; lsu_wb_valid = 1; cycle();
    chk("arb2_lsu", rf_waddr, 7);
    lsu_wb_valid = 0; cycle();
    chk("arb2_alu", rf_waddr, 3);
    alu_wb_valid = 0;
    chk("arb_clear", busy_vec, 0);

    // x0 destination: never tracked, never written
    set_issue(1, 1, 0, 0, 0); cycle();
    chk("x0_busy", busy_vec, 0);
    set_issue(0, 0, 0, 0, 0);
    lsu_wb_valid = 1; lsu_wb_rd = 0; lsu_wb_data = 64'hDEAD; cycle();
    chk("x0_rf_we", rf_we, 0);
    lsu_wb_valid = 0;

    // WAW stall on rd=9
    set_issue(1, 1, 9, 0, 0); cycle();
    cycle(); cycle();
    lsu_wb_valid = 1; lsu_wb_rd = 9; lsu_wb_data = 64'h99; cycle();
    lsu_wb_valid = 0; cycle();
    chk("waw_reissued", busy_vec, 32'h200);
    set_issue(0, 0, 0, 0, 0);
    alu_wb_valid = 1; alu_wb_rd = 9; alu_wb_data = 64'h9A; cycle();
    alu_wb_valid = 0;

    // Flush drops the scoreboard but lets a concurrent writeback commit
    set_issue(1, 1, 5, 0, 0); cycle();
    set_issue(1, 1, 10, 0, 0); cycle();
    set_issue(1, 1, 11, 0, 0); cycle();
    set_issue(0, 0, 0, 0, 0);
    chk("fl_pre", busy_vec, 32'h0C20);
    flush = 1; alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 64'h55; cycle();
    chk("fl_busy", busy_vec, 0);
    chk("fl_rf_we", rf_we, 1);
    chk("fl_err", wb_err, 0);
    flush = 0; alu_wb_valid = 0; cycle(); cycle();
    alu_wb_valid = 1; alu_wb_rd = 11; alu_wb_data = 64'hBB; cycle();
    chk("err_set", wb_err, 1);
    alu_wb_valid = 0;

    // Reset while ALU waits on a lost conflict
    alu_wb_valid = 1; alu_wb_rd = 0; lsu_wb_valid = 1; lsu_wb_rd = 0; cycle();
    cycle();
    rst = 1; cycle();
    chk("mid_rst_err", wb_err, 0);
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_wa", rf_waddr, 0);
    rst = 0; alu_wb_valid = 0; lsu_wb_valid = 0;
    g_ga = 0; g_gl = 0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit was_rst = rst;
      rst   = ($urandom % 400 == 0);
      flush = ($urandom % 25 == 0);
      if (!(alu_wb_valid && !g_ga && !was_rst)) begin
        alu_wb_valid = ($urandom % 100 < 40);
        alu_wb_rd = pick_rd(); alu_wb_data = {$urandom, $urandom};
      end
      if (!(lsu_wb_valid && !g_gl && !was_rst)) begin
        lsu_wb_valid = ($urandom % 100 < 40);
        lsu_wb_rd = pick_rd(); lsu_wb_data = {$urandom, $urandom};
      end
      issue_valid = ($urandom % 100 < 70);
      issue_we = issue_valid && ($urandom % 2 == 0);
      issue_rd = 5'($urandom % 12);
      issue_rs1 = 5'($urandom % 12);
      issue_rs2 = 5'($urandom % 12);
      // a destination must not be issued while a writeback to it is pending
      if (issue_we && ((alu_wb_valid && issue_rd == alu_wb_rd) ||
                       (lsu_wb_valid && issue_rd == lsu_wb_rd)))
        issue_we = 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
